// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared FSM state type and width helpers for the clock frequency monitor
package clk_mon_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_e;

    function automatic int gate_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int diff_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/clk_freq_monitor_if.sv
// clk_freq_monitor_if: measured clock, enable and results bundle; CLK_MON_MINMAX_EN adds count_min/count_max
interface clk_freq_monitor_if #(
    parameter int CNT_W = 16
);
    logic             meas_clk;
    logic             enable;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             in_range;
    logic             stuck;
    logic             locked;
    logic             lost;
`ifdef CLK_MON_MINMAX_EN
    logic [CNT_W-1:0] count_min;
    logic [CNT_W-1:0] count_max;

    modport master (
        output meas_clk, enable,
        input  count, count_valid, in_range, stuck, locked, lost, count_min, count_max
    );
    modport slave (
        input  meas_clk, enable,
        output count, count_valid, in_range, stuck, locked, lost, count_min, count_max
    );
`else
    modport master (
        output meas_clk, enable,
        input  count, count_valid, in_range, stuck, locked, lost
    );
    modport slave (
        input  meas_clk, enable,
        output count, count_valid, in_range, stuck, locked, lost
    );
`endif
endinterface

// File: rtl/clk_mon_edge_sync.sv
// clk_mon_edge_sync: 2-FF synchroniser plus rising-edge pulse for an asynchronous input
module clk_mon_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        sync_q <= rst ? 3'b000 : {sync_q[1:0], async_i};
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: gated edge count of meas_clk vs refclk with range check and lock; CLK_MON_MINMAX_EN adds min/max tracking
module clk_freq_monitor
    import clk_mon_pkg::*;
#(
    parameter int GATE_CYCLES  = 24000,
    parameter int CNT_W        = 16,
    parameter int EXP_COUNT    = 4020,
    parameter int TOL          = 8,
    parameter int LOCK_WINDOWS = 4
) (
    input logic               refclk,
    input logic               reset,
    clk_freq_monitor_if.slave mon
);
    localparam int GW = gate_w(GATE_CYCLES);
    localparam int DW = diff_w(CNT_W);
    localparam int LW = gate_w(LOCK_WINDOWS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                 state_q;
    logic [GW-1:0]          gate_q;
    logic [CNT_W-1:0]       edges_q, edges_d, count_q;
    logic [LW-1:0]          good_q, good_d;
    logic                   valid_q, in_range_q, stuck_q, locked_q, lost_q;
    logic                   edge_p, win_end, eval, in_range_d;
    logic signed [DW-1:0]   diff, adiff;

    clk_mon_edge_sync u_sync (
        .clk     (refclk),
        .rst     (reset),
        .async_i (mon.meas_clk),
        .rise_o  (edge_p)
    );

    // An edge arriving on the closing cycle is folded into that window's result.
    always_comb begin
        win_end    = gate_q == GW'(GATE_CYCLES - 1);
        eval       = mon.enable && state_q == MEASURE && win_end;
        edges_d    = (edge_p && edges_q != CNT_MAX) ? edges_q + CNT_W'(1) : edges_q;
        diff       = $signed({1'b0, edges_d}) - $signed(DW'(EXP_COUNT));
        adiff      = diff[DW-1] ? -diff : diff;
        in_range_d = adiff <= $signed(DW'(TOL));
        good_d     = good_q == LW'(LOCK_WINDOWS) ? good_q : good_q + LW'(1);
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            edges_q    <= '0;
            count_q    <= '0;
            good_q     <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            stuck_q    <= 1'b0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
            if (!mon.enable) begin
                state_q  <= IDLE;
                gate_q   <= '0;
                edges_q  <= '0;
                good_q   <= '0;
                locked_q <= 1'b0;
            end else if (state_q == IDLE) begin
                state_q <= SETTLE;
            end else begin
                gate_q  <= win_end ? '0 : gate_q + GW'(1);
                edges_q <= win_end ? '0 : edges_d;
                if (win_end)
                    state_q <= MEASURE;
                if (eval) begin
                    valid_q    <= 1'b1;
                    count_q    <= edges_d;
                    in_range_q <= in_range_d;
                    stuck_q    <= edges_d == '0;
                    good_q     <= in_range_d ? good_d : '0;
                    locked_q   <= in_range_d && good_d == LW'(LOCK_WINDOWS);
                    lost_q     <= !in_range_d && locked_q;
                end
            end
        end
    end

    assign mon.count       = count_q;
    assign mon.count_valid = valid_q;
    assign mon.in_range    = in_range_q;
    assign mon.stuck       = stuck_q;
    assign mon.locked      = locked_q;
    assign mon.lost        = lost_q;

`ifdef CLK_MON_MINMAX_EN
    logic [CNT_W-1:0] min_q, max_q;
    logic             first_q;

    // Extremes restart from the first result after each enable rise.
    always_ff @(posedge refclk) begin
        if (reset) begin
            min_q   <= '0;
            max_q   <= '0;
            first_q <= 1'b1;
        end else if (state_q == IDLE) begin
            first_q <= 1'b1;
        end else if (eval) begin
            min_q   <= (first_q || edges_d < min_q) ? edges_d : min_q;
            max_q   <= (first_q || edges_d > max_q) ? edges_d : max_q;
            first_q <= 1'b0;
        end
    end

    assign mon.count_min = min_q;
    assign mon.count_max = max_q;
`endif
endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb_clk_freq_monitor: directed scenarios checked against a window-sum model of meas_clk edges
module tb_clk_freq_monitor;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int G   = 240;
    localparam int EXP = 40;
    localparam int TOL = 2;
    localparam int LW  = 4;
    localparam int CW  = 16;

    logic refclk = 1'b0;
    logic reset  = 1'b1;
    real  mper   = 250.0;

    clk_freq_monitor_if #(.CNT_W(CW)) mon ();

    clk_freq_monitor #(
        .GATE_CYCLES  (G),
        .CNT_W        (CW),
        .EXP_COUNT    (EXP),
        .TOL          (TOL),
        .LOCK_WINDOWS (LW)
    ) dut (
        .refclk (refclk),
        .reset  (reset),
        .mon    (mon)
    );

    always #20.834 refclk = ~refclk;

    // meas_clk: period mper, or held low when mper is zero
    initial begin
        mon.meas_clk = 1'b0;
        #7.3;
        forever begin
            if (mper == 0.0) begin
                mon.meas_clk = 1'b0;
                #10;
            end else begin
                mon.meas_clk = ~mon.meas_clk;
                #(mper / 2.0);
            end
        end
    end

    int n_asrt, n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_asrt++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Model: true meas_clk rises per refclk cycle; a window result sums the G cycles
    // ending 3 cycles (synchroniser + detect) before the valid edge.
    int  cyc, rises, n, good, e_cnt, e_min, e_max;
    int  hist [0:49999];
    bit  run, started, e_valid, e_locked, e_lost, e_inr, amb, cur_amb, zero_out, mm_first, mm_have;

    function automatic bit inr(input int x);
        return (x - EXP <= TOL) && (EXP - x <= TOL);
    endfunction

    always @(posedge mon.meas_clk) rises++;

    always @(posedge refclk) begin
        cyc++;
        hist[cyc] = rises;
        rises = 0;
        started = 1;
        e_valid = 0;
        e_lost = 0;
        if (reset) begin
            run = 0;
            good = 0;
            e_locked = 0;
            amb = 0;
            zero_out = 1;
            mm_first = 1;
            mm_have = 0;
        end else if (!mon.enable) begin
            run = 0;
            good = 0;
            e_locked = 0;
            amb = 0;
            mm_first = 1;
        end else begin
            n = run ? n + 1 : 1;
            run = 1;
            if (n > 2 * G && (n - 1) % G == 0) begin
                e_cnt = 0;
                for (int i = cyc - G - 1; i <= cyc - 2; i++) e_cnt += hist[i];
                e_valid = 1;
                zero_out = 0;
                cur_amb = inr(e_cnt - 1) != inr(e_cnt) || inr(e_cnt + 1) != inr(e_cnt);
                amb = amb | cur_amb;
                e_inr = inr(e_cnt);
                if (e_inr) begin
                    good = good < LW ? good + 1 : LW;
                    e_locked = good == LW;
                end else begin
                    e_lost = e_locked;
                    e_locked = 0;
                    good = 0;
                end
                e_min = (mm_first || e_cnt < e_min) ? e_cnt : e_min;
                e_max = (mm_first || e_cnt > e_max) ? e_cnt : e_max;
                mm_first = 0;
                mm_have = 1;
            end
        end
    end

    always @(negedge refclk) begin
        if (started) begin
            chk("count_valid", mon.count_valid, e_valid);
            if (!amb) begin
                chk("locked", mon.locked, e_locked);
                chk("lost", mon.lost, e_lost);
            end
            if (e_valid) begin
                chk_rng("count", int'(mon.count), e_cnt - 1, e_cnt + 1);
                if (!cur_amb) chk("in_range", mon.in_range, e_inr);
                if (e_cnt != 1) chk("stuck", mon.stuck, e_cnt == 0);
            end
            if (zero_out) begin
                chk("zero_count", mon.count, 0);
                chk("zero_in_range", mon.in_range, 0);
                chk("zero_stuck", mon.stuck, 0);
            end
`ifdef CLK_MON_MINMAX_EN
            if (mm_have) begin
                chk_rng("count_min", int'(mon.count_min), e_min - 1, e_min + 1);
                chk_rng("count_max", int'(mon.count_max), e_max - 1, e_max + 1);
            end else begin
                chk("count_min_zero", mon.count_min, 0);
                chk("count_max_zero", mon.count_max, 0);
            end
`endif
        end
    end

    task automatic wait_valid(input string nm, input int lim, output int w);
        w = -1;
        for (int i = 1; i <= lim; i++) begin
            @(negedge refclk);
            if (mon.count_valid) begin
                w = i;
                break;
            end
        end
        chk({nm, "_seen"}, w > 0, 1);
    endtask

    task automatic count_valids(input int cycles, output int nv, output int fv);
        nv = 0;
        fv = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge refclk);
            if (mon.count_valid) begin
                nv++;
                if (fv == 0) fv = i;
            end
        end
    endtask

    initial begin
        repeat (45000) @(posedge refclk);
        $display("FAIL watchdog: got no end of test, expected finish within 45000 cycles");
        $fatal(1);
    end

    initial begin
        int w, nv, fv;
        mon.enable = 1'b0;
        repeat (3) @(negedge refclk);
        chk("rst_count", mon.count, 0);
        chk("rst_valid", mon.count_valid, 0);
        chk("rst_locked", mon.locked, 0);
        reset = 1'b0;
        @(negedge refclk);
        // lock acquisition at 250 ns
        mon.enable = 1'b1;
        wait_valid("first", 600, w);
        chk("first_valid_cycle", w, 481);
        chk_rng("first_count", int'(mon.count), 39, 41);
        chk("first_in_range", mon.in_range, 1);
        chk("first_stuck", mon.stuck, 0);
        chk("first_locked", mon.locked, 0);
        for (int k = 2; k <= 4; k++) begin
            wait_valid("lock", 300, w);
            chk("valid_period", w, 240);
            chk("locked_at_valid", mon.locked, k == 4);
        end
        // frequency excursion to 200 ns
        mper = 200.0;
        wait_valid("fast", 300, w);
        chk_rng("fast_count", int'(mon.count), 48, 51);
        chk("fast_in_range", mon.in_range, 0);
        chk("fast_locked", mon.locked, 0);
        chk("fast_lost", mon.lost, 1);
        @(negedge refclk);
        chk("lost_one_cycle", mon.lost, 0);
        mper = 250.0;
        for (int k = 1; k <= 4; k++) begin
            wait_valid("relock", 300, w);
            chk("relocked_at_valid", mon.locked, k == 4);
        end
        // disable mid-window while locked
        repeat (100) @(negedge refclk);
        mon.enable = 1'b0;
        @(negedge refclk);
        chk("dis_locked", mon.locked, 0);
        chk("dis_lost", mon.lost, 0);
        count_valids(300, nv, fv);
        chk("dis_no_valid", nv, 0);
        mon.enable = 1'b1;
        count_valids(600, nv, fv);
        chk("reen_first_valid", fv, 481);
        chk("reen_valids", nv, 1);
        mon.enable = 1'b0;
        @(negedge refclk);
        chk("dis600_locked", mon.locked, 0);
        chk("dis600_lost", mon.lost, 0);
        count_valids(300, nv, fv);
        chk("dis600_no_valid", nv, 0);
        mon.enable = 1'b1;
        wait_valid("reen2", 600, w);
        chk("reen2_valid_cycle", w, 481);
        // stuck clock
        mper = 0.0;
        wait_valid("stuck_a", 300, w);
        wait_valid("stuck_b", 300, w);
        chk("stuck_count", mon.count, 0);
        chk("stuck_flag", mon.stuck, 1);
        chk("stuck_in_range", mon.in_range, 0);
        chk("stuck_locked", mon.locked, 0);
        chk("stuck_lost", mon.lost, 0);
        // relock then reset mid-MEASURE
        mper = 250.0;
        for (int k = 1; k <= 4; k++) wait_valid("prerst", 300, w);
        chk("prerst_locked", mon.locked, 1);
        repeat (100) @(negedge refclk);
        reset = 1'b1;
        @(negedge refclk);
        chk("rst2_count", mon.count, 0);
        chk("rst2_valid", mon.count_valid, 0);
        chk("rst2_in_range", mon.in_range, 0);
        chk("rst2_stuck", mon.stuck, 0);
        chk("rst2_locked", mon.locked, 0);
        chk("rst2_lost", mon.lost, 0);
        reset = 1'b0;
        count_valids(200, nv, fv);
        chk("rst2_no_valid", nv, 0);
        wait_valid("post_rst", 400, w);
        chk("post_rst_valid_cycle", w + 200, 481);
`ifdef CLK_MON_MINMAX_EN
        for (int k = 0; k < 4; k++) begin
            mper = (k % 2 == 0) ? 240.0 : 260.0;
            wait_valid("alt", 300, w);
        end
        chk_rng("alt_min", int'(mon.count_min), 37, 40);
        chk_rng("alt_max", int'(mon.count_max), 41, 43);
        reset = 1'b1;
        @(negedge refclk);
        reset = 1'b0;
        chk("rst3_min", mon.count_min, 0);
        chk("rst3_max", mon.count_max, 0);
`endif
        repeat (5) @(negedge refclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
